// File: rtl/flit_transmitter_if.sv
// Packet-request, payload and flit-output signals of the flit transmitter.
// master = transmitter side, slave = the driving/receiving environment.
interface flit_transmitter_if #(
  parameter int VC_NUM = 4,
  parameter int LEN_W  = 4,
  parameter int X_W    = 4,
  parameter int Y_W    = 4,
  parameter int DATA_W = 16,
  parameter int FLIT_W = 20
) ();
  logic              pkt_valid_i;
  logic              pkt_ready_o;
  logic [X_W-1:0]    x_dest_i;
  logic [Y_W-1:0]    y_dest_i;
  logic [LEN_W-1:0]  pkt_len_i;
  logic [DATA_W-1:0] payload_i;
  logic              payload_valid_i;
  logic              payload_ready_o;
  logic [VC_NUM-1:0] on_off_i;
  logic [VC_NUM-1:0] is_allocatable_i;
  logic [FLIT_W-1:0] data_o;
  logic              valid_flit_o;
  logic              busy_o;

  modport master (
    input  pkt_valid_i, x_dest_i, y_dest_i, pkt_len_i,
    input  payload_i, payload_valid_i, on_off_i, is_allocatable_i,
    output pkt_ready_o, payload_ready_o, data_o, valid_flit_o, busy_o
  );

  modport slave (
    output pkt_valid_i, x_dest_i, y_dest_i, pkt_len_i,
    output payload_i, payload_valid_i, on_off_i, is_allocatable_i,
    input  pkt_ready_o, payload_ready_o, data_o, valid_flit_o, busy_o
  );
endinterface

// File: rtl/flit_transmitter.sv
// NoC flit types plus a packet-to-flit transmitter: picks a free downstream VC
// round-robin, then streams HEAD/BODY/TAIL flits gated by that VC's on/off flag.
package noc_params;
  localparam int VC_NUM            = 4;
  localparam int VC_SIZE           = $clog2(VC_NUM);
  localparam int DEST_ADDR_SIZE_X  = 4;
  localparam int DEST_ADDR_SIZE_Y  = 4;
  localparam int FLIT_DATA_SIZE    = 16;
  localparam int HEAD_PAYLOAD_SIZE = FLIT_DATA_SIZE - DEST_ADDR_SIZE_X - DEST_ADDR_SIZE_Y;

  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

  typedef struct packed {
    logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
    logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
  } head_data_t;

  typedef union packed {
    head_data_t                head_data;
    logic [FLIT_DATA_SIZE-1:0] bt_pl;
  } flit_data_t;

  typedef struct packed {
    flit_label_t        flit_label;
    logic [VC_SIZE-1:0] vc_id;
    flit_data_t         data;
  } flit_t;
endpackage

module flit_transmitter #(
  parameter int VC_NUM   = noc_params::VC_NUM,
  parameter int MAX_BODY = 15
) (
  input logic          clk,
  input logic          rst,
  flit_transmitter_if.master bus
);
  localparam int LEN_W = $clog2(MAX_BODY + 1);
  localparam int VC_W  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int X_W   = noc_params::DEST_ADDR_SIZE_X;
  localparam int Y_W   = noc_params::DEST_ADDR_SIZE_Y;

  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

  state_t              state_reg;
  logic [VC_W-1:0]     rr_ptr_reg;
  logic [VC_W-1:0]     vc_reg;
  logic [LEN_W-1:0]    len_reg;
  logic [LEN_W-1:0]    remaining_reg;
  logic [X_W-1:0]      x_reg;
  logic [Y_W-1:0]      y_reg;
  noc_params::flit_t   data_reg;
  logic                valid_reg;

  logic [VC_NUM-1:0]   eligible;
  logic [VC_W-1:0]     pick;
  logic                found;
  int                  pick_idx;
  logic [VC_W-1:0]     vc_inc;
  logic [LEN_W-1:0]    len_sat;
  logic                pkt_ready;
  logic                payload_ready;
  noc_params::flit_t   head_flit;
  noc_params::flit_t   body_flit;

  assign eligible      = bus.is_allocatable_i & bus.on_off_i;
  assign pkt_ready     = (state_reg == IDLE) && (|eligible);
  assign payload_ready = (state_reg == BODY) && bus.on_off_i[vc_reg];

  // First eligible VC at or after rr_ptr, wrapping around.
  always_comb begin
    pick     = rr_ptr_reg;
    found    = 1'b0;
    pick_idx = 0;
    for (int k = 0; k < VC_NUM; k++) begin
      pick_idx = (int'(rr_ptr_reg) + k) % VC_NUM;
      if (!found && eligible[pick_idx]) begin
        pick  = VC_W'(pick_idx);
        found = 1'b1;
      end
    end
  end

  assign vc_inc  = (vc_reg == VC_W'(VC_NUM - 1)) ? '0 : vc_reg + 1'b1;
  assign len_sat = ({1'b0, bus.pkt_len_i} > (LEN_W + 1)'(MAX_BODY)) ? LEN_W'(MAX_BODY)
                                                                    : bus.pkt_len_i;

  always_comb begin
    head_flit                        = '0;
    head_flit.flit_label             = (len_reg == '0) ? noc_params::HEADTAIL : noc_params::HEAD;
    head_flit.vc_id                  = noc_params::VC_SIZE'(vc_reg);
    head_flit.data.head_data.x_dest  = x_reg;
    head_flit.data.head_data.y_dest  = y_reg;
  end

  always_comb begin
    body_flit            = '0;
    body_flit.flit_label = (remaining_reg > LEN_W'(1)) ? noc_params::BODY : noc_params::TAIL;
    body_flit.vc_id      = noc_params::VC_SIZE'(vc_reg);
    body_flit.data.bt_pl = bus.payload_i;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      vc_reg        <= '0;
      len_reg       <= '0;
      remaining_reg <= '0;
      x_reg         <= '0;
      y_reg         <= '0;
      data_reg      <= '0;
      valid_reg     <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.pkt_valid_i && pkt_ready) begin
            x_reg     <= bus.x_dest_i;
            y_reg     <= bus.y_dest_i;
            len_reg   <= len_sat;
            vc_reg    <= pick;
            state_reg <= HEAD;
          end
        end
        HEAD: begin
          if (bus.on_off_i[vc_reg]) begin
            data_reg  <= head_flit;
            valid_reg <= 1'b1;
            // A single-flit packet releases the VC just like a tail does.
            if (len_reg == '0) begin
              state_reg  <= IDLE;
              rr_ptr_reg <= vc_inc;
            end else begin
              state_reg     <= BODY;
              remaining_reg <= len_reg;
            end
          end
        end
        BODY: begin
          if (bus.payload_valid_i && payload_ready) begin
            data_reg      <= body_flit;
            valid_reg     <= 1'b1;
            remaining_reg <= remaining_reg - 1'b1;
            if (remaining_reg <= LEN_W'(1)) begin
              state_reg  <= IDLE;
              rr_ptr_reg <= vc_inc;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.pkt_ready_o     = pkt_ready;
  assign bus.payload_ready_o = payload_ready;
  assign bus.data_o          = data_reg;
  assign bus.valid_flit_o    = valid_reg;
  assign bus.busy_o          = (state_reg != IDLE);
endmodule

// File: tb/tb_flit_transmitter.sv
// Directed scenario bench for flit_transmitter; every flit seen on the output
// is logged with its cycle number and checked against hand-computed values.
module tb_flit_transmitter;
  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   cyc;
  int   pl_base;
  int   pl_idx;

  noc_params::flit_t fq[$];
  int                cq[$];

  flit_transmitter_if #(
    .VC_NUM(4), .LEN_W(4), .X_W(4), .Y_W(4), .DATA_W(16),
    .FLIT_W($bits(noc_params::flit_t))
  ) ifc ();

  flit_transmitter #(.VC_NUM(4), .MAX_BODY(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (ifc.valid_flit_o === 1'b1) begin
      fq.push_back(noc_params::flit_t'(ifc.data_o));
      cq.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input int x, input int y, input int len);
    bit ok;
    ok = 1'b0;
    ifc.x_dest_i    = 4'(x);
    ifc.y_dest_i    = 4'(y);
    ifc.pkt_len_i   = 4'(len);
    ifc.pkt_valid_i = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (ifc.pkt_ready_o === 1'b1) ok = 1'b1;
      step();
    end
    ifc.pkt_valid_i = 1'b0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL send_pkt_accept: pkt_ready_o never high within 20 cycles");
    end
  endtask

  task automatic pump(input int n);
    bit hs;
    repeat (n) begin
      #1;
      hs = ifc.payload_ready_o && ifc.payload_valid_i;
      step();
      if (hs) begin
        pl_idx++;
        ifc.payload_i = 16'(pl_base + pl_idx);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    tests++;
    if (ifc.valid_flit_o !== 1'b0) begin
      fails++; $display("FAIL reset_valid: got %b want 0", ifc.valid_flit_o);
    end
    tests++;
    if (ifc.busy_o !== 1'b0) begin
      fails++; $display("FAIL reset_busy: got %b want 0", ifc.busy_o);
    end
    tests++;
    if (ifc.data_o !== '0) begin
      fails++; $display("FAIL reset_data: got %h want 0", ifc.data_o);
    end
    tests++;
    if (ifc.pkt_ready_o !== 1'b0 || ifc.payload_ready_o !== 1'b0) begin
      fails++; $display("FAIL reset_ready: pkt %b payload %b want 0 0", ifc.pkt_ready_o, ifc.payload_ready_o);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_headtail();
    fq.delete(); cq.delete();
    ifc.on_off_i         = 4'hF;
    ifc.is_allocatable_i = 4'hF;
    #1;
    tests++;
    if (ifc.pkt_ready_o !== 1'b1) begin
      fails++; $display("FAIL ht_pkt_ready: got %b want 1", ifc.pkt_ready_o);
    end
    send_pkt(3, 2, 0);
    tests++;
    if (ifc.busy_o !== 1'b1) begin
      fails++; $display("FAIL ht_busy: got %b want 1", ifc.busy_o);
    end
    step();
    step();
    tests++;
    if (ifc.valid_flit_o !== 1'b0 || fq.size() != 1) begin
      fails++; $display("FAIL ht_single_flit: flits %0d valid %b want 1 flit valid 0", fq.size(), ifc.valid_flit_o);
    end else begin
      tests++;
      if (fq[0].flit_label !== noc_params::HEADTAIL || fq[0].vc_id !== 2'd0 ||
          fq[0].data.head_data.x_dest !== 4'd3 || fq[0].data.head_data.y_dest !== 4'd2) begin
        fails++;
        $display("FAIL ht_flit: label %0d vc %0d x %0d y %0d want 3 0 3 2", fq[0].flit_label,
                 fq[0].vc_id, fq[0].data.head_data.x_dest, fq[0].data.head_data.y_dest);
      end
    end
    send_pkt(5, 6, 0);
    step();
    step();
    tests++;
    if (fq.size() != 2) begin
      fails++; $display("FAIL ht_second_count: got %0d want 2", fq.size());
    end else if (fq[1].vc_id !== 2'd1) begin
      fails++; $display("FAIL ht_second_vc: got %0d want 1", fq[1].vc_id);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_lbl[4];
    exp_lbl[0] = noc_params::HEAD; exp_lbl[1] = noc_params::BODY;
    exp_lbl[2] = noc_params::BODY; exp_lbl[3] = noc_params::TAIL;
    fq.delete(); cq.delete();
    pl_base = 'hA; pl_idx = 0;
    ifc.payload_i = 16'hA;
    ifc.payload_valid_i = 1'b1;
    send_pkt(1, 1, 3);
    pump(4);
    tests++;
    if (ifc.busy_o !== 1'b0 || ifc.pkt_ready_o !== 1'b1) begin
      fails++; $display("FAIL b2b_after_tail: busy %b pkt_ready %b want 0 1", ifc.busy_o, ifc.pkt_ready_o);
    end
    step();
    tests++;
    if (fq.size() != 4) begin
      fails++; $display("FAIL b2b_count: got %0d want 4", fq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (fq[i].flit_label !== exp_lbl[i] || fq[i].vc_id !== 2'd2 || cq[i] !== cq[0] + i ||
            (i > 0 && fq[i].data.bt_pl !== 16'('hA + i - 1))) begin
          fails++;
          $display("FAIL b2b_flit%0d: label %0d vc %0d data %h cyc+%0d want %0d 2 %h +%0d", i,
                   fq[i].flit_label, fq[i].vc_id, fq[i].data.bt_pl, cq[i] - cq[0], exp_lbl[i],
                   16'('hA + i - 1), i);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [1:0] exp_lbl[4];
    int         exp_gap[4];
    exp_lbl[0] = noc_params::HEAD; exp_lbl[1] = noc_params::BODY;
    exp_lbl[2] = noc_params::BODY; exp_lbl[3] = noc_params::TAIL;
    exp_gap[0] = 0; exp_gap[1] = 1; exp_gap[2] = 4; exp_gap[3] = 5;
    fq.delete(); cq.delete();
    pl_base = 'h10; pl_idx = 0;
    ifc.payload_i = 16'h10;
    send_pkt(7, 1, 3);
    pump(2);
    ifc.on_off_i = 4'b0111;
    #1;
    tests++;
    if (ifc.payload_ready_o !== 1'b0) begin
      fails++; $display("FAIL stall_payload_ready: got %b want 0", ifc.payload_ready_o);
    end
    pump(2);
    tests++;
    if (fq.size() != 2) begin
      fails++; $display("FAIL stall_no_flits: got %0d flits want 2", fq.size());
    end
    ifc.on_off_i = 4'hF;
    pump(3);
    step();
    tests++;
    if (fq.size() != 4) begin
      fails++; $display("FAIL stall_count: got %0d want 4", fq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (fq[i].flit_label !== exp_lbl[i] || fq[i].vc_id !== 2'd3 || cq[i] - cq[0] !== exp_gap[i] ||
            (i > 0 && fq[i].data.bt_pl !== 16'('h10 + i - 1))) begin
          fails++;
          $display("FAIL stall_flit%0d: label %0d vc %0d data %h cyc+%0d want %0d 3 %h +%0d", i,
                   fq[i].flit_label, fq[i].vc_id, fq[i].data.bt_pl, cq[i] - cq[0], exp_lbl[i],
                   16'('h10 + i - 1), exp_gap[i]);
        end
      end
    end
  endtask

  task automatic test_alloc();
    fq.delete(); cq.delete();
    ifc.payload_valid_i  = 1'b0;
    ifc.is_allocatable_i = 4'b0010;
    send_pkt(2, 3, 0);
    step();
    step();
    tests++;
    if (fq.size() != 1 || fq[0].vc_id !== 2'd1) begin
      fails++; $display("FAIL alloc_vc1: flits %0d vc %0d want 1 1", fq.size(), fq.size() ? fq[0].vc_id : 2'd0);
    end
    ifc.is_allocatable_i = 4'b0000;
    ifc.x_dest_i = 4'd9; ifc.y_dest_i = 4'd4; ifc.pkt_len_i = 4'd0;
    ifc.pkt_valid_i = 1'b1;
    #1;
    tests++;
    if (ifc.pkt_ready_o !== 1'b0) begin
      fails++; $display("FAIL alloc_none_ready: got %b want 0", ifc.pkt_ready_o);
    end
    step(); step(); step();
    tests++;
    if (ifc.busy_o !== 1'b0 || fq.size() != 1) begin
      fails++; $display("FAIL alloc_held: busy %b flits %0d want 0 1", ifc.busy_o, fq.size());
    end
    ifc.is_allocatable_i = 4'b1000;
    #1;
    tests++;
    if (ifc.pkt_ready_o !== 1'b1) begin
      fails++; $display("FAIL alloc_release_ready: got %b want 1", ifc.pkt_ready_o);
    end
    step();
    ifc.pkt_valid_i = 1'b0;
    step();
    step();
    tests++;
    if (fq.size() != 2) begin
      fails++; $display("FAIL alloc_held_count: got %0d want 2", fq.size());
    end else if (fq[1].vc_id !== 2'd3 || fq[1].data.head_data.x_dest !== 4'd9) begin
      fails++; $display("FAIL alloc_held_flit: vc %0d x %0d want 3 9", fq[1].vc_id, fq[1].data.head_data.x_dest);
    end
    ifc.is_allocatable_i = 4'hF;
  endtask

  task automatic test_reset_mid();
    send_pkt(0, 0, 0);
    step();
    step();
    fq.delete(); cq.delete();
    pl_base = 'h20; pl_idx = 0;
    ifc.payload_i = 16'h20;
    ifc.payload_valid_i = 1'b1;
    send_pkt(1, 2, 3);
    pump(2);
    tests++;
    if (ifc.busy_o !== 1'b1) begin
      fails++; $display("FAIL rmid_busy_before: got %b want 1", ifc.busy_o);
    end
    rst = 1'b0;
    step();
    tests++;
    if (ifc.valid_flit_o !== 1'b0 || ifc.busy_o !== 1'b0 || ifc.data_o !== '0) begin
      fails++; $display("FAIL rmid_after_reset: valid %b busy %b data %h want 0 0 0",
                        ifc.valid_flit_o, ifc.busy_o, ifc.data_o);
    end
    rst = 1'b1;
    pump(3);
    tests++;
    if (fq.size() != 2 || fq[0].vc_id !== 2'd1) begin
      fails++; $display("FAIL rmid_abandoned: flits %0d want 2 (no tail) on vc 1", fq.size());
    end
    ifc.payload_valid_i = 1'b0;
    send_pkt(4, 4, 0);
    step();
    step();
    tests++;
    if (fq.size() != 3) begin
      fails++; $display("FAIL rmid_next_count: got %0d want 3", fq.size());
    end else if (fq[2].vc_id !== 2'd0) begin
      fails++; $display("FAIL rmid_next_vc: got %0d want 0", fq[2].vc_id);
    end
  endtask

  task automatic test_max_len();
    logic [1:0] lbl;
    ifc.is_allocatable_i = 4'b0100;
    send_pkt(0, 0, 0);
    step();
    step();
    ifc.is_allocatable_i = 4'hF;
    fq.delete(); cq.delete();
    pl_base = 'h40; pl_idx = 0;
    ifc.payload_i = 16'h40;
    ifc.payload_valid_i = 1'b1;
    send_pkt(15, 15, 15);
    pump(17);
    step();
    tests++;
    if (fq.size() != 16) begin
      fails++; $display("FAIL max_count: got %0d want 16", fq.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        lbl = (i == 0) ? noc_params::HEAD : (i == 15) ? noc_params::TAIL : noc_params::BODY;
        tests++;
        if (fq[i].flit_label !== lbl || fq[i].vc_id !== 2'd3 || cq[i] !== cq[0] + i ||
            (i > 0 && fq[i].data.bt_pl !== 16'('h40 + i - 1))) begin
          fails++;
          $display("FAIL max_flit%0d: label %0d vc %0d data %h cyc+%0d want %0d 3 %h +%0d", i,
                   fq[i].flit_label, fq[i].vc_id, fq[i].data.bt_pl, cq[i] - cq[0], lbl,
                   16'('h40 + i - 1), i);
        end
      end
    end
    ifc.payload_valid_i = 1'b0;
    send_pkt(1, 1, 0);
    step();
    step();
    tests++;
    if (fq.size() != 17) begin
      fails++; $display("FAIL max_wrap_count: got %0d want 17", fq.size());
    end else if (fq[16].vc_id !== 2'd0) begin
      fails++; $display("FAIL max_wrap_vc: got %0d want 0", fq[16].vc_id);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cyc   = 0;
    pl_base = 0;
    pl_idx  = 0;
    rst = 1'b0;
    ifc.pkt_valid_i      = 1'b0;
    ifc.x_dest_i         = '0;
    ifc.y_dest_i         = '0;
    ifc.pkt_len_i        = '0;
    ifc.payload_i        = '0;
    ifc.payload_valid_i  = 1'b0;
    ifc.on_off_i         = '0;
    ifc.is_allocatable_i = '0;

    test_reset();
    test_headtail();
    test_back_to_back();
    test_stall();
    test_alloc();
    test_reset_mid();
    test_max_len();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/flit_transmitter.md
FLIT_TRANSMITTER -- requirements
Module: flit_transmitter

Interface
REQ-001 SHALL use parameter VC_NUM, default noc_params VC_NUM, meaning the number of downstream virtual channels.
REQ-002 SHALL use parameter MAX_BODY, default 15, meaning the maximum body+tail flits per packet; pkt_len_i width is $clog2(MAX_BODY+1).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-low, so rst=0 sampled at a clk edge resets the block.
REQ-005 SHALL have port pkt_valid_i, input, 1, meaning a new packet request is present.
REQ-006 SHALL have port pkt_ready_o, output, 1, meaning the packet request is accepted this cycle.
REQ-007 SHALL have ports x_dest_i and y_dest_i, inputs, DEST_ADDR_SIZE_X and DEST_ADDR_SIZE_Y, meaning the packet destination.
REQ-008 SHALL have port pkt_len_i, input, $clog2(MAX_BODY+1), meaning the body+tail flit count; 0 means a single HEADTAIL flit.
REQ-009 SHALL have ports payload_i (input, flit data width), payload_valid_i (input, 1) and payload_ready_o (output, 1), forming the body/tail payload handshake.
REQ-010 SHALL have port on_off_i, input, [VC_NUM-1:0], the downstream per-VC on/off flag; 1 means the VC can accept a flit.
REQ-011 SHALL have port is_allocatable_i, input, [VC_NUM-1:0], meaning the downstream VC is free for a new packet.
REQ-012 SHALL have ports data_o (output, flit_t) and valid_flit_o (output, 1), the flit toward the downstream input port.
REQ-013 SHALL have port busy_o, output, 1, asserted when the state is not IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, HEAD and BODY.
REQ-015 SHALL define eligible as is_allocatable_i & on_off_i; pkt_ready_o SHALL equal (state==IDLE) && |eligible, combinationally.
REQ-016 On pkt_valid_i && pkt_ready_o, SHALL latch the destination and length and pick a VC: the first eligible VC at or after rr_ptr, wrapping modulo VC_NUM. The state then goes to HEAD.
REQ-017 In HEAD with on_off_i[vc]=1, SHALL emit the head flit: vc_id=vc, head_data.x_dest/y_dest set to the latched values, and flit_label=HEADTAIL if len==0, else HEAD.
REQ-018 After a HEADTAIL flit, SHALL return to IDLE. After a HEAD flit, SHALL go to BODY with remaining=len.
REQ-019 In HEAD with on_off_i[vc]=0, SHALL hold state and emit nothing.
REQ-020 In BODY, payload_ready_o SHALL equal on_off_i[vc]. payload_ready_o is 0 in all other states.
REQ-021 In BODY, a payload handshake SHALL emit a flit with data=payload_i, vc_id=vc, and label BODY if remaining>1, else TAIL. Each such flit decrements remaining.
REQ-022 On a TAIL flit, SHALL go to IDLE and set rr_ptr=(vc+1) mod VC_NUM.
REQ-023 data_o and valid_flit_o SHALL be registered; an emitted flit appears the cycle after the deciding edge.
REQ-024 valid_flit_o SHALL be high for exactly one cycle per flit. data_o holds its last value while valid_flit_o=0.
REQ-025 Back-to-back operation SHALL proceed without bubbles: HEAD and BODY flits on consecutive cycles while on_off and payload_valid stay high; a new packet may be accepted the cycle after the tail is emitted.
REQ-026 Changes to on_off_i or is_allocatable_i mid-packet SHALL not change the selected VC; only on_off_i[vc] gates progress.
REQ-027 pkt_len_i above MAX_BODY SHALL be saturated to MAX_BODY.

Reset
REQ-028 With rst=0 at a clk edge, SHALL set state=IDLE, rr_ptr=0, vc=0, remaining=0, valid_flit_o=0, data_o=0 and busy_o=0 on the following cycle, regardless of the current state.
REQ-029 A packet interrupted by reset SHALL be abandoned; no tail flit is sent.

Verification
REQ-030 Reset, all VCs eligible, len=0 to (3,2) -> one HEADTAIL flit, vc_id=0, x=3, y=2, valid high 1 cycle; the next packet uses vc_id=1.
REQ-031 len=3, payload 0xA,0xB,0xC always valid, on_off all 1 -> HEAD,BODY,BODY,TAIL on 4 consecutive cycles with data A,B,C; busy_o then drops.
REQ-032 on_off_i[vc]=0 for 2 cycles after the first BODY -> payload_ready_o=0, no flits for 2 cycles, then the remaining BODY/TAIL resume in order.
REQ-033 is_allocatable_i=4'b0010 with pkt_valid_i -> the packet goes to vc_id=1; is_allocatable_i=4'b0000 -> pkt_ready_o=0 and the request is held.
REQ-034 rst=0 asserted in BODY with remaining=2 -> next cycle valid_flit_o=0, busy_o=0, and the next packet uses vc_id=0.
REQ-035 len=MAX_BODY=15, rr_ptr=VC_NUM-1 -> 1 HEAD + 14 BODY + 1 TAIL on vc VC_NUM-1, after which rr_ptr wraps to 0.
